// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus sequencer: FSM states, memory-op kinds and
// the full-word byteenable constant.
package mips_bus_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      EXEC   = 3'd1,
      MEM    = 3'd2,
      COMMIT = 3'd3,
      HALTED = 3'd4
   } bus_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } mem_op_t;

   localparam logic [3:0] BE_ALL = 4'hF;

   // A store takes precedence when the decoder flags both kinds of access.
   function automatic mem_op_t decode_op(input logic rd_i, input logic wr_i);
      if (wr_i) begin
         return WR;
      end else if (rd_i) begin
         return RD;
      end else begin
         return NONE;
      end
   endfunction

endpackage

// File: rtl/mips_avalon_port.sv
// Avalon master mux: selects fetch or data-access signals from the sequencer
// state and holds address/byteenable/writedata steady while the slave stalls.
module mips_avalon_port
   import mips_bus_pkg::*;
#(
   parameter logic [3:0] FETCH_BE = BE_ALL
) (
   input  logic        clk,
   input  logic        reset,
   input  bus_state_t  state_i,
   input  mem_op_t     mem_op_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] store_data_i,
   input  logic [3:0]  store_be_i,
   input  logic        waitrequest_i,
   output logic [31:0] address_o,
   output logic        read_o,
   output logic        write_o,
   output logic [3:0]  byteenable_o,
   output logic [31:0] writedata_o
);

   logic        rd_s;
   logic        wr_s;
   logic [31:0] addr_s;
   logic [3:0]  be_s;
   logic [31:0] wd_s;
   logic        hold_d;
   logic        hold_q;
   logic [31:0] addr_q;
   logic [3:0]  be_q;
   logic [31:0] wd_q;

   always_comb begin
      rd_s   = 1'b0;
      wr_s   = 1'b0;
      addr_s = 32'h0000_0000;
      be_s   = 4'h0;
      wd_s   = 32'h0000_0000;
      case (state_i)
         FETCH: begin
            rd_s   = 1'b1;
            addr_s = pc_i;
            be_s   = FETCH_BE;
         end
         MEM: begin
            case (mem_op_i)
               RD: begin
                  rd_s   = 1'b1;
                  addr_s = data_addr_i;
                  be_s   = FETCH_BE;
               end
               WR: begin
                  wr_s   = 1'b1;
                  addr_s = data_addr_i;
                  be_s   = store_be_i;
                  wd_s   = store_data_i;
               end
               default: begin
                  rd_s = 1'b0;
               end
            endcase
         end
         default: begin
            rd_s = 1'b0;
         end
      endcase
   end

   // A stalled cycle arms the hold so the next cycle replays the captured beat.
   assign hold_d = (rd_s | wr_s) & waitrequest_i;

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q <= 1'b0;
         addr_q <= 32'h0000_0000;
         be_q   <= 4'h0;
         wd_q   <= 32'h0000_0000;
      end else begin
         hold_q <= hold_d;
         if (!hold_q) begin
            addr_q <= addr_s;
            be_q   <= be_s;
            wd_q   <= wd_s;
         end
      end
   end

   assign address_o    = hold_q ? addr_q : addr_s;
   assign byteenable_o = hold_q ? be_q   : be_s;
   assign writedata_o  = hold_q ? wd_q   : wd_s;
   assign read_o       = rd_s & ~reset;
   assign write_o      = wr_s & ~reset;

endmodule

// File: rtl/mips_bus_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/COMMIT sequencer sharing one Avalon port between
// instruction fetch and data access; architectural writes happen only in COMMIT.
module mips_bus_sequencer
   import mips_bus_pkg::*;
#(
   parameter logic [3:0] FETCH_BE = BE_ALL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic [31:0] data_addr,
   input  logic [31:0] store_data,
   input  logic [3:0]  store_be,
   input  logic        data_read,
   input  logic        data_write,
   input  logic        halt,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic [31:0] instr_reg,
   output logic [31:0] load_data,
   output logic        pc_wren,
   output logic        reg_commit,
   output logic        active
);

   bus_state_t  state_q, state_d;
   mem_op_t     mem_op_q, mem_op_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] load_q, load_d;

   always_comb begin
      state_d  = state_q;
      mem_op_d = mem_op_q;
      instr_d  = instr_q;
      load_d   = load_q;
      case (state_q)
         FETCH: begin
            if (!waitrequest) begin
               instr_d = readdata;
               state_d = EXEC;
            end else begin
               state_d = FETCH;
            end
         end
         EXEC: begin
            mem_op_d = decode_op(data_read, data_write);
            if (mem_op_d == NONE) begin
               state_d = COMMIT;
            end else begin
               state_d = MEM;
            end
         end
         MEM: begin
            if (!waitrequest) begin
               if (mem_op_q == RD) begin
                  load_d = readdata;
               end else begin
                  load_d = load_q;
               end
               state_d = COMMIT;
            end else begin
               state_d = MEM;
            end
         end
         COMMIT: begin
            if (halt) begin
               state_d = HALTED;
            end else begin
               state_d = FETCH;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         mem_op_q <= NONE;
         instr_q  <= 32'h0000_0000;
         load_q   <= 32'h0000_0000;
      end else begin
         state_q  <= state_d;
         mem_op_q <= mem_op_d;
         instr_q  <= instr_d;
         load_q   <= load_d;
      end
   end

   mips_avalon_port #(
      .FETCH_BE (FETCH_BE)
   ) u_port (
      .clk           (clk),
      .reset         (reset),
      .state_i       (state_q),
      .mem_op_i      (mem_op_q),
      .pc_i          (pc),
      .data_addr_i   (data_addr),
      .store_data_i  (store_data),
      .store_be_i    (store_be),
      .waitrequest_i (waitrequest),
      .address_o     (address),
      .read_o        (read),
      .write_o       (write),
      .byteenable_o  (byteenable),
      .writedata_o   (writedata)
   );

   assign instr_reg  = instr_q;
   assign load_data  = load_q;
   assign pc_wren    = (state_q == COMMIT);
   assign reg_commit = (state_q == COMMIT);
   assign active     = (state_q != HALTED) && !reset;

endmodule

// File: tb/tb_mips_bus_sequencer.sv
// Scoreboard bench for mips_bus_sequencer: stimulus queues expected bus beats
// and commits; a negedge monitor answers the bus and checks what the DUT shows.
module tb_mips_bus_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc, data_addr, store_data;
   logic [3:0]  store_be;
   logic        data_read, data_write, halt;
   logic [31:0] address, writedata, readdata, instr_reg, load_data;
   logic        read, write, waitrequest, pc_wren, reg_commit, active;
   logic [3:0]  byteenable;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } bus_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] ld;
   } cmt_t;

   bus_t        bus_q[$];
   cmt_t        cmt_q[$];
   int          vectors = 0;
   int          errors = 0;
   int          fetch_waits = 0;
   int          mem_waits = 0;
   int          stall_cnt = 0;
   logic [31:0] fetch_word = 32'h0;
   logic [31:0] load_word = 32'h0;
   logic [31:0] exp_load = 32'h0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_wd;
   logic [3:0]  prev_be;
   logic        prev_rd, prev_wr;

   always #5 clk = ~clk;

   mips_bus_sequencer #(.FETCH_BE(4'hF)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .data_addr   (data_addr),
      .store_data  (store_data),
      .store_be    (store_be),
      .data_read   (data_read),
      .data_write  (data_write),
      .halt        (halt),
      .address     (address),
      .read        (read),
      .write       (write),
      .byteenable  (byteenable),
      .writedata   (writedata),
      .waitrequest (waitrequest),
      .readdata    (readdata),
      .instr_reg   (instr_reg),
      .load_data   (load_data),
      .pc_wren     (pc_wren),
      .reg_commit  (reg_commit),
      .active      (active)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave model and monitor: decide waitrequest/readdata, then check the cycle.
   always begin : mon
      bus_t e;
      cmt_t c;
      @(negedge clk);
      if ((read || write) &&
          stall_cnt < (((read && address == pc)) ? fetch_waits : mem_waits)) begin
         waitrequest = 1'b1;
         stall_cnt++;
      end else begin
         waitrequest = 1'b0;
         stall_cnt = 0;
      end
      readdata = waitrequest ? 32'hBAD0_BAD0 : ((address == pc) ? fetch_word : load_word);
      #1;
      if (read || write) check("rd_wr_exclusive", 32'(read & write), 32'd0);
      if (prev_stall && !reset) begin
         check("hold_addr", address, prev_addr);
         check("hold_be", 32'(byteenable), 32'(prev_be));
         check("hold_strobe", 32'({read, write}), 32'({prev_rd, prev_wr}));
         if (write) check("hold_wdata", writedata, prev_wd);
      end
      prev_stall = (read || write) && waitrequest;
      prev_addr  = address;
      prev_be    = byteenable;
      prev_wd    = writedata;
      prev_rd    = read;
      prev_wr    = write;
      if ((read || write) && !waitrequest) begin
         if (bus_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL bus_unexpected: got rd=%b wr=%b addr %h expected no transfer", read, write, address);
         end else begin
            e = bus_q.pop_front();
            check("bus_kind_is_write", 32'(write), 32'(e.wr));
            check("bus_kind_is_read", 32'(read), 32'(!e.wr));
            check("bus_addr", address, e.addr);
            check("bus_be", 32'(byteenable), 32'(e.be));
            if (e.wr) check("bus_wdata", writedata, e.wd);
         end
      end
      if (pc_wren || reg_commit) begin
         check("commit_pair", 32'({pc_wren, reg_commit}), 32'd3);
         if (cmt_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL commit_unexpected: got pc_wren=%b expected none", pc_wren);
         end else begin
            c = cmt_q.pop_front();
            check("commit_instr_reg", instr_reg, c.instr);
            check("commit_load_data", load_data, c.ld);
         end
      end
   end

   task automatic run_instr(input logic [31:0] ipc, input logic [31:0] iword,
                            input bit rd, input bit wr, input logic [31:0] daddr,
                            input logic [31:0] sdata, input logic [3:0] sbe,
                            input logic [31:0] lword, input int fw, input int mw,
                            input bit hlt);
      int cyc;
      bit done;
      pc = ipc; fetch_word = iword; data_read = rd; data_write = wr;
      data_addr = daddr; store_data = sdata; store_be = sbe; load_word = lword;
      fetch_waits = fw; mem_waits = mw; halt = hlt;
      bus_q.push_back('{1'b0, ipc, 4'hF, 32'h0});
      if (wr) begin
         bus_q.push_back('{1'b1, daddr, sbe, sdata});
      end else if (rd) begin
         bus_q.push_back('{1'b0, daddr, 4'hF, 32'h0});
         exp_load = lword;
      end
      cmt_q.push_back('{iword, exp_load});
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         #2;
         cyc++;
         if (cyc == 1) begin
            check("first_cycle_read", 32'(read), 32'd1);
            check("first_cycle_active", 32'(active), 32'd1);
         end
         if (cyc == fw + 2) check("exec_instr_reg", instr_reg, iword);
         if (pc_wren) done = 1'b1;
      end
      if (!done) begin
         vectors++;
         errors++;
         $display("FAIL commit_timeout: got no commit in %0d cycles expected one", cyc);
      end else begin
         check("latency", 32'(cyc), 32'(3 + fw + ((rd || wr) ? 1 + mw : 0)));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; pc = 32'h0; data_addr = 32'h0; store_data = 32'h0;
      store_be = 4'h0; data_read = 1'b0; data_write = 1'b0; halt = 1'b0;
      waitrequest = 1'b0; readdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      check("reset_strobes", 32'({read, write, pc_wren, reg_commit, active}), 32'd0);
      check("reset_instr_reg", instr_reg, 32'h0);
      check("reset_load_data", load_data, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      run_instr(32'hBFC0_0000, 32'h0085_1021, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                32'h0, 0, 0, 1'b0);
      run_instr(32'hBFC0_0004, 32'h8C82_0000, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0,
                32'hDEAD_BEEF, 1, 2, 1'b0);
      run_instr(32'hBFC0_0008, 32'hAC82_0004, 1'b0, 1'b1, 32'h0000_2004,
                32'h0000_ABCD, 4'b0011, 32'h5555_5555, 0, 2, 1'b0);
      run_instr(32'hBFC0_000C, 32'hAC83_0000, 1'b1, 1'b1, 32'h0000_3000,
                32'h1234_5678, 4'b1100, 32'h6666_6666, 0, 1, 1'b0);

      // Load that stalls forever, cut short by reset.
      pc = 32'hBFC0_0014; fetch_word = 32'h8C83_0000; data_read = 1'b1;
      data_write = 1'b0; data_addr = 32'h0000_4000; load_word = 32'hCAFE_F00D;
      fetch_waits = 0; mem_waits = 1000; halt = 1'b0;
      bus_q.push_back('{1'b0, 32'hBFC0_0014, 4'hF, 32'h0});
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      #2;
      check("reset_cycle_read", 32'(read), 32'd0);
      check("reset_cycle_pc_wren", 32'(pc_wren), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_waits = 0;
      exp_load = 32'h0;
      check("post_reset_instr_reg", instr_reg, 32'h0);
      check("post_reset_load_data", load_data, 32'h0);

      run_instr(32'hBFC0_0000, 32'h0109_5020, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                32'h0, 0, 0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         check("halted_quiet", 32'({read, write, pc_wren, reg_commit, active}), 32'd0);
      end
      check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
      check("commit_queue_empty", 32'(cmt_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mips_bus_sequencer.md
# mips_bus_sequencer

Multi-cycle sequencer that shares the CPU's single Avalon memory port between instruction fetch and data load/store. It sits between the decoder's `data_read`/`data_write` outputs and the external bus, steps each instruction through FETCH, EXEC, optional MEM and COMMIT, and stalls on `waitrequest`. It gates PC and register-file writes so that architectural state changes exactly once per instruction, in COMMIT.

## Interface
Parameters:
- FETCH_BE, 4'hF, byteenable driven for fetches and loads.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  current PC from the datapath.
- data_addr  in  32  ALU-computed load/store address.
- store_data  in  32  aligned store data.
- store_be  in  4  store byte enables.
- data_read  in  1  decoder load indication, sampled in EXEC.
- data_write  in  1  decoder store indication, sampled in EXEC.
- halt  in  1  datapath indication that the committing instruction's next PC is 0.
- address  out  32  Avalon address.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- byteenable  out  4  Avalon byteenable.
- writedata  out  32  Avalon writedata.
- waitrequest  in  1  Avalon stall.
- readdata  in  32  Avalon read data.
- instr_reg  out  32  latched instruction word, feeds the decoder.
- load_data  out  32  latched load word.
- pc_wren  out  1  one-cycle PC update strobe.
- reg_commit  out  1  one-cycle register-file / HI / LO write qualifier.
- active  out  1  CPU running; low once halted.

## Operation
- States: FETCH, EXEC, MEM, COMMIT, HALTED.
- FETCH:
  - Drive `read`=1, `address`=pc, `byteenable`=FETCH_BE.
  - On a cycle with `!waitrequest`, latch `readdata` into `instr_reg` and go to EXEC. Otherwise stay in FETCH.
- EXEC:
  - One cycle, no bus activity; the decoder and ALU settle from `instr_reg`.
  - If `data_write`, go to MEM (write). Else if `data_read`, go to MEM (read). Else go to COMMIT.
  - If both are asserted, write wins and the read is dropped.
  - The kind of access is registered here, so MEM is immune to decoder changes.
- MEM, read:
  - Drive `read`=1, `address`=data_addr, `byteenable`=FETCH_BE.
  - On `!waitrequest`, latch `readdata` into `load_data` and go to COMMIT.
- MEM, write:
  - Drive `write`=1, `address`=data_addr, `writedata`=store_data, `byteenable`=store_be.
  - On `!waitrequest`, go to COMMIT.
- COMMIT:
  - Assert `pc_wren`=1 and `reg_commit`=1 for exactly this cycle.
  - If `halt`, go to HALTED. Otherwise go to FETCH.
- HALTED:
  - All bus strobes 0, `active`=0, `pc_wren`/`reg_commit` stay 0.
  - Held until `reset`.
- Address is passed through unmodified. Byte-lane selection and LWL/LWR merging happen downstream from `load_data`.
- While any strobe is high and `waitrequest`=1:
  - `address`, `byteenable` and `writedata` are held stable.
  - `read` and `write` are never both high.

## Timing
- Reset values, applied at the first edge with `reset`=1:
  - state=FETCH; `instr_reg`=0; `load_data`=0.
  - `read`, `write`, `pc_wren`, `reg_commit`=0.
  - `active`=0 while `reset` is high; `active`=1 from the first cycle after reset deassertion.
- `read`/`write` are forced to 0 combinationally while `reset`=1. The first fetch is issued in the cycle after reset falls.
- Cycle counts at zero wait states:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, COMMIT).
  - Load or store: 4 cycles.
  - Each `waitrequest` cycle adds one cycle to FETCH or MEM.
- `readdata` is sampled only in a cycle with `read`=1 and `waitrequest`=0. It is ignored otherwise.
- `pc_wren` and `reg_commit` are driven from state (Moore) and are never asserted outside COMMIT.
- Reset mid-transfer: the strobe drops during the reset cycle and the machine restarts in FETCH. There is no commit, and the latched registers are cleared.
- `halt` is sampled only in COMMIT. Assertions in other states have no effect.

## Structure
- Package `mips_bus_pkg` holds:
  - the `bus_state_t` enum (FETCH, EXEC, MEM, COMMIT, HALTED);
  - the `BE_ALL` constant (4'hF);
  - the `mem_op_t` enum (NONE, RD, WR).
- One sub-module, `mips_avalon_port`: a registered mux that drives and holds `address`/`byteenable`/`writedata` and the strobes from state plus `mem_op`. The top-level FSM owns the transitions and the `instr_reg`/`load_data` latches.

## Test plan
- Reset, then ALU instruction, zero wait:
  - `pc`=0xBFC00000, `readdata`=0x00851021.
  - Required: `read` in cycle 1; `instr_reg`=0x00851021 in EXEC; `pc_wren`/`reg_commit` pulse once in cycle 3; next fetch in cycle 4.
- Load with 2 wait cycles:
  - `data_read`=1, `data_addr`=0x1000, `readdata`=0xDEADBEEF.
  - Required: `read` held with `address`=0x1000 for 3 cycles; `load_data`=0xDEADBEEF; commit after the MEM stall.
- Store:
  - `data_write`=1, `store_be`=4'b0011, `store_data`=0x0000ABCD.
  - Required: `write`=1, `byteenable`=0011, `writedata`=0x0000ABCD, stable under `waitrequest`; `read` never asserted.
- Halt:
  - `halt`=1 in COMMIT.
  - Required: next state HALTED; `active`=0; no further strobes for 20 cycles.
- Reset during a stalled MEM read:
  - Required: `read`=0 in the reset cycle; no `pc_wren`; fetch restarts after reset falls.
- Both `data_read` and `data_write` in EXEC:
  - Required: only `write` is issued.
